// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg
//   Shared types for the writeback unit: the buffered result entry, the
//   RV32I load funct3 codes and the arbiter round-robin state.
package writeback_unit_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  funct3;
        logic [1:0]  byteOff;
        logic        isLoad;
    } tWbEntry;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        RR_LOAD = 1'b0,
        RR_ALU  = 1'b1
    } tRrState;

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if
//   Bundles the producer handshakes (ALU, load), the issue-side scoreboard
//   port and the register-file write port of the writeback unit.
//   slave  : the writeback unit itself
//   master : producers / issue logic / register file side
interface writeback_unit_if #(
    parameter int XLEN = 32
);
    logic            iAluValid;
    logic            oAluReady;
    logic [4:0]      iAluRd;
    logic [XLEN-1:0] iAluData;

    logic            iLdValid;
    logic            oLdReady;
    logic [4:0]      iLdRd;
    logic [2:0]      iLdFunct3;
    logic [1:0]      iLdByteOff;
    logic [XLEN-1:0] iLdWord;

    logic            iIssueValid;
    logic [4:0]      iIssueRd;
    logic [31:0]     oBusy;

    logic [4:0]      oRdAddr;
    logic            oRdWe;
    logic [XLEN-1:0] oRdData;
    logic            oLdErr;

    modport slave (
        input  iAluValid, iAluRd, iAluData,
        input  iLdValid, iLdRd, iLdFunct3, iLdByteOff, iLdWord,
        input  iIssueValid, iIssueRd,
        output oAluReady, oLdReady, oBusy,
        output oRdAddr, oRdWe, oRdData, oLdErr
    );

    modport master (
        output iAluValid, iAluRd, iAluData,
        output iLdValid, iLdRd, iLdFunct3, iLdByteOff, iLdWord,
        output iIssueValid, iIssueRd,
        input  oAluReady, oLdReady, oBusy,
        input  oRdAddr, oRdWe, oRdData, oLdErr
    );
endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// wb_fifo
//   Synchronous FIFO of tWbEntry. Pointers wrap naturally because DEPTH is
//   a power of two. Push while full and pop while empty are ignored.
//   Ports: iClk, iRst (sync, active high), push/pushEntry, pop/head,
//          count (occupancy), empty.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     push,
    input  tWbEntry                  pushEntry,
    input  logic                     pop,
    output tWbEntry                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    tWbEntry        mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic           full;
    logic           doPush;
    logic           doPop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign head   = mem[rdPtr];

    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
//   Buffers ALU and load results, arbitrates one register-file write per
//   cycle, formats load data at pop time and keeps a pending-write
//   scoreboard for the issue logic.
//   Ports: iClk, iRst (sync, active high), bus (writeback_unit_if.slave):
//          ALU/load valid-ready inputs, issue rd, oBusy scoreboard,
//          oRdAddr/oRdWe/oRdData write port, oLdErr drop pulse.
//
//   Arbiter state | meaning
//   RR_LOAD       | load FIFO wins the next contended cycle
//   RR_ALU        | ALU FIFO wins the next contended cycle
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            iClk,
    input  logic            iRst,
    writeback_unit_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tWbEntry         aluIn, ldIn, aluHead, ldHead, popEntry;
    logic            aluPush, ldPush, aluPop, ldPop, popValid;
    logic            aluEmpty, ldEmpty, aluReady, ldReady;
    logic [CW-1:0]   aluCount, ldCount;
    tRrState         rrState, rrNext;
    logic [32:0]     fmt;
    logic [31:0]     busyQ, busyNext;
    logic [4:0]      rdAddrQ;
    logic            rdWeQ, ldErrQ;
    logic [XLEN-1:0] rdDataQ;

    // Returns {err, data}; misaligned or undefined loads set err.
    function automatic logic [32:0] fmtLoad(input tWbEntry e);
        logic [7:0]  b;
        logic [15:0] h;
        case (e.byteOff)
            2'd0:    b = e.data[7:0];
            2'd1:    b = e.data[15:8];
            2'd2:    b = e.data[23:16];
            default: b = e.data[31:24];
        endcase
        h = e.byteOff[1] ? e.data[31:16] : e.data[15:0];
        case (e.funct3)
            LB:      fmtLoad = {1'b0, {24{b[7]}}, b};
            LBU:     fmtLoad = {1'b0, 24'd0, b};
            LH:      fmtLoad = {e.byteOff[0], {16{h[15]}}, h};
            LHU:     fmtLoad = {e.byteOff[0], 16'd0, h};
            LW:      fmtLoad = {(e.byteOff != 2'd0), e.data};
            default: fmtLoad = {1'b1, 32'd0};
        endcase
    endfunction

    // Ready depends only on the registered occupancy, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    assign aluReady = (aluCount < CW'(FIFO_DEPTH));
    assign ldReady  = (ldCount < CW'(FIFO_DEPTH));

    // rd==0 consumes the handshake but is never buffered.
    assign aluPush = bus.iAluValid && aluReady && (bus.iAluRd != 5'd0);
    assign ldPush  = bus.iLdValid && ldReady && (bus.iLdRd != 5'd0);

    assign aluIn = '{rd: bus.iAluRd, data: bus.iAluData, funct3: 3'd0,
                     byteOff: 2'd0, isLoad: 1'b0};
    assign ldIn  = '{rd: bus.iLdRd, data: bus.iLdWord, funct3: bus.iLdFunct3,
                     byteOff: bus.iLdByteOff, isLoad: 1'b1};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) uAluFifo (
        .iClk(iClk), .iRst(iRst), .push(aluPush), .pushEntry(aluIn),
        .pop(aluPop), .head(aluHead), .count(aluCount), .empty(aluEmpty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) uLdFifo (
        .iClk(iClk), .iRst(iRst), .push(ldPush), .pushEntry(ldIn),
        .pop(ldPop), .head(ldHead), .count(ldCount), .empty(ldEmpty)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rrState <= RR_LOAD;
        end else begin
            rrState <= rrNext;
        end
    end

    always_comb begin
        rrNext = rrState;
        if (!aluEmpty && !ldEmpty) begin
            rrNext = (rrState == RR_LOAD) ? RR_ALU : RR_LOAD;
        end
    end

    always_comb begin
        ldPop  = 1'b0;
        aluPop = 1'b0;
        if (!ldEmpty && (aluEmpty || rrState == RR_LOAD)) begin
            ldPop = 1'b1;
        end else if (!aluEmpty) begin
            aluPop = 1'b1;
        end
    end

    assign popValid = ldPop || aluPop;
    assign popEntry = ldPop ? ldHead : aluHead;

    always_comb begin
        if (popEntry.isLoad) begin
            fmt = fmtLoad(popEntry);
        end else begin
            fmt = {1'b0, popEntry.data};
        end
    end

    // Clear first, then set, so a same-edge issue keeps the bit busy.
    always_comb begin
        busyNext = busyQ;
        if (popValid) begin
            busyNext[popEntry.rd] = 1'b0;
        end
        if (bus.iIssueValid) begin
            busyNext[bus.iIssueRd] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdWeQ   <= 1'b0;
            ldErrQ  <= 1'b0;
            rdAddrQ <= '0;
            rdDataQ <= '0;
            busyQ   <= '0;
        end else begin
            rdWeQ  <= popValid && !fmt[32];
            ldErrQ <= popValid && fmt[32];
            if (popValid && !fmt[32]) begin
                rdAddrQ <= popEntry.rd;
                rdDataQ <= fmt[31:0];
            end
            busyQ <= busyNext;
        end
    end

    assign bus.oAluReady = aluReady;
    assign bus.oLdReady  = ldReady;
    assign bus.oBusy     = busyQ;
    assign bus.oRdAddr   = rdAddrQ;
    assign bus.oRdWe     = rdWeQ;
    assign bus.oRdData   = rdDataQ;
    assign bus.oLdErr    = ldErrQ;
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    writeback_unit_if #(.XLEN(32)) bus ();

    writeback_unit #(.FIFO_DEPTH(2), .XLEN(32)) dut (
        .iClk(clk),
        .iRst(rst),
        .bus (bus)
    );

    // Issuing to an already-busy register is a protocol violation.
    always @(posedge clk) begin
        if (!rst && bus.iIssueValid && bus.iIssueRd != 5'd0) begin
            assert (!bus.oBusy[bus.iIssueRd])
            else $error("FAIL issue_to_busy rd=%0d", bus.iIssueRd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iAluValid   = 1'b0;
        bus.iAluRd      = 5'd0;
        bus.iAluData    = 32'd0;
        bus.iLdValid    = 1'b0;
        bus.iLdRd       = 5'd0;
        bus.iLdFunct3   = 3'd0;
        bus.iLdByteOff  = 2'd0;
        bus.iLdWord     = 32'd0;
        bus.iIssueValid = 1'b0;
        bus.iIssueRd    = 5'd0;
    endtask

    typedef struct {
        bit          isLd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] word;
        bit          expWe;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t aluQ[$];
    exp_t ldQ[$];

    // Reference load result straight from the RV32I rules.
    function automatic exp_t ref_load(input logic [4:0] rd, input logic [2:0] f3,
                                      input logic [1:0] off, input logic [31:0] word);
        exp_t        e;
        logic [31:0] sh;
        sh    = word >> (8 * off);
        e.rd  = rd;
        e.err = 1'b0;
        case (f3)
            3'b000: e.data = 32'($signed(sh[7:0]));
            3'b100: e.data = {24'd0, sh[7:0]};
            3'b001: begin e.err = off[0]; e.data = 32'($signed(sh[15:0])); end
            3'b101: begin e.err = off[0]; e.data = {16'd0, sh[15:0]}; end
            3'b010: begin e.err = (off != 2'd0); e.data = word; end
            default: begin e.err = 1'b1; e.data = 32'd0; end
        endcase
        return e;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        if (v.isLd) begin
            bus.iLdValid   = 1'b1;
            bus.iLdRd      = v.rd;
            bus.iLdFunct3  = v.f3;
            bus.iLdByteOff = v.off;
            bus.iLdWord    = v.word;
        end else begin
            bus.iAluValid = 1'b1;
            bus.iAluRd    = v.rd;
            bus.iAluData  = v.word;
        end
        bus.iIssueValid = 1'b1;
        bus.iIssueRd    = v.rd;
        @(posedge clk); #1;
        idle_inputs();
        chk($sformatf("v%0d_busy_set", idx), bus.oBusy, (v.rd != 5'd0) ? (32'd1 << v.rd) : 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_we", idx), {31'd0, bus.oRdWe}, {31'd0, v.expWe});
        chk($sformatf("v%0d_err", idx), {31'd0, bus.oLdErr}, {31'd0, v.expErr});
        if (v.expWe) begin
            chk($sformatf("v%0d_addr", idx), {27'd0, bus.oRdAddr}, {27'd0, v.rd});
            chk($sformatf("v%0d_data", idx), bus.oRdData, v.expData);
        end
        chk($sformatf("v%0d_busy_clr", idx), bus.oBusy, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", idx), {30'd0, bus.oRdWe, bus.oLdErr}, 32'd0);
    endtask

    task automatic mon();
        exp_t e;
        chk("we_err_excl", {31'd0, bus.oRdWe & bus.oLdErr}, 32'd0);
        if (bus.oRdWe) begin
            if (bus.oRdAddr < 5'd16) begin
                if (aluQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL alu_unexpected: got addr=%0d want none", bus.oRdAddr);
                end else begin
                    e = aluQ.pop_front();
                    chk("alu_wr_rd", {27'd0, bus.oRdAddr}, {27'd0, e.rd});
                    chk("alu_wr_data", bus.oRdData, e.data);
                end
            end else begin
                if (ldQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ld_unexpected: got addr=%0d want none", bus.oRdAddr);
                end else begin
                    e = ldQ.pop_front();
                    chk("ld_wr_kind", 32'd0, {31'd0, e.err});
                    chk("ld_wr_rd", {27'd0, bus.oRdAddr}, {27'd0, e.rd});
                    chk("ld_wr_data", bus.oRdData, e.data);
                end
            end
        end
        if (bus.oLdErr) begin
            if (ldQ.size() == 0) begin
                total++; bad++;
                $display("FAIL ld_err_unexpected: got err=1 want none");
            end else begin
                e = ldQ.pop_front();
                chk("ld_err_kind", {31'd0, bus.oLdErr}, {31'd0, e.err});
            end
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [2:0]  f3tab[8];
        logic [4:0]  obsRd[$];
        logic [31:0] obsData[$];
        int          obsCyc[$];
        logic [4:0]  stRd[8];
        logic [31:0] stData[8];
        int          aI, lI;
        bit          aX, lX;
        exp_t        e;

        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_we", {31'd0, bus.oRdWe}, 32'd0);
        chk("rst_addr", {27'd0, bus.oRdAddr}, 32'd0);
        chk("rst_data", bus.oRdData, 32'd0);
        chk("rst_busy", bus.oBusy, 32'd0);
        chk("rst_err", {31'd0, bus.oLdErr}, 32'd0);
        chk("rst_ready", {30'd0, bus.oAluReady, bus.oLdReady}, 32'd3);

        vecs.push_back('{0, 5'd5,  3'd0, 2'd0, 32'h1234_5678, 1, 32'h1234_5678, 0});
        vecs.push_back('{1, 5'd7,  LB,   2'd3, 32'h80FF_FF7F, 1, 32'hFFFF_FF80, 0});
        vecs.push_back('{1, 5'd7,  LBU,  2'd3, 32'h80FF_FF7F, 1, 32'h0000_0080, 0});
        vecs.push_back('{1, 5'd8,  LHU,  2'd2, 32'hBEEF_0000, 1, 32'h0000_BEEF, 0});
        vecs.push_back('{1, 5'd9,  LW,   2'd1, 32'h1111_2222, 0, 32'd0,        1});
        vecs.push_back('{1, 5'd9,  3'b011, 2'd0, 32'h1111_2222, 0, 32'd0,      1});
        vecs.push_back('{0, 5'd0,  3'd0, 2'd0, 32'hFFFF_FFFF, 0, 32'd0,        0});
        vecs.push_back('{1, 5'd12, LB,   2'd0, 32'h80FF_FF7F, 1, 32'h0000_007F, 0});
        vecs.push_back('{1, 5'd13, LH,   2'd2, 32'h80FF_FF7F, 1, 32'hFFFF_80FF, 0});
        vecs.push_back('{1, 5'd14, LH,   2'd1, 32'h80FF_FF7F, 0, 32'd0,        1});
        vecs.push_back('{1, 5'd31, LW,   2'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0});
        vecs.push_back('{1, 5'd15, 3'b110, 2'd0, 32'h0000_0001, 0, 32'd0,      1});
        vecs.push_back('{1, 5'd16, LBU,  2'd1, 32'h80FF_FF7F, 1, 32'h0000_00FF, 0});
        vecs.push_back('{1, 5'd17, LHU,  2'd0, 32'h80FF_FF7F, 1, 32'h0000_FF7F, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], i);
        end

        // Issue rd=3 on the same edge its (un-issued) write registers.
        @(posedge clk); #1;
        bus.iAluValid = 1'b1; bus.iAluRd = 5'd3; bus.iAluData = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        idle_inputs();
        bus.iIssueValid = 1'b1; bus.iIssueRd = 5'd3;
        @(posedge clk); #1;
        idle_inputs();
        chk("setwin_we", {31'd0, bus.oRdWe}, 32'd1);
        chk("setwin_addr", {27'd0, bus.oRdAddr}, 32'd3);
        chk("setwin_busy", bus.oBusy, 32'h0000_0008);

        // Both sources stream rd=1..4; writes must alternate load/ALU.
        for (int i = 0; i < 4; i++) begin
            stRd[2*i]     = 5'(i + 1);
            stData[2*i]   = 32'hB000_0000 + 32'(i);
            stRd[2*i+1]   = 5'(i + 1);
            stData[2*i+1] = 32'hA000_0000 + 32'(i);
        end
        aI = 0; lI = 0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && obsRd.size() < 8; cyc++) begin
            bus.iAluValid = (aI < 4);
            bus.iAluRd    = 5'(aI + 1);
            bus.iAluData  = 32'hA000_0000 + 32'(aI);
            bus.iLdValid  = (lI < 4);
            bus.iLdRd     = 5'(lI + 1);
            bus.iLdFunct3 = LW;
            bus.iLdByteOff = 2'd0;
            bus.iLdWord   = 32'hB000_0000 + 32'(lI);
            @(negedge clk);
            if (bus.oRdWe) begin
                obsRd.push_back(bus.oRdAddr);
                obsData.push_back(bus.oRdData);
                obsCyc.push_back(cyc);
            end
            aX = bus.iAluValid && bus.oAluReady;
            lX = bus.iLdValid && bus.oLdReady;
            @(posedge clk); #1;
            if (aX) aI++;
            if (lX) lI++;
        end
        idle_inputs();
        chk("stream_count", obsRd.size(), 8);
        for (int i = 0; i < obsRd.size() && i < 8; i++) begin
            chk($sformatf("stream_rd%0d", i), {27'd0, obsRd[i]}, {27'd0, stRd[i]});
            chk($sformatf("stream_data%0d", i), obsData[i], stData[i]);
        end
        if (obsCyc.size() == 8) begin
            chk("stream_gapless", obsCyc[7] - obsCyc[0], 7);
        end
        repeat (3) @(posedge clk);

        // Randomized traffic; ALU uses rd 0..15, loads rd 16..31.
        f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        #1;
        for (int cyc = 0; cyc < 612; cyc++) begin
            @(negedge clk);
            mon();
            aX = bus.iAluValid && bus.oAluReady;
            lX = bus.iLdValid && bus.oLdReady;
            if (aX && bus.iAluRd != 5'd0) begin
                e.rd = bus.iAluRd; e.data = bus.iAluData; e.err = 1'b0;
                aluQ.push_back(e);
            end
            if (lX) begin
                ldQ.push_back(ref_load(bus.iLdRd, bus.iLdFunct3, bus.iLdByteOff, bus.iLdWord));
            end
            @(posedge clk); #1;
            if (aX || !bus.iAluValid) begin
                bus.iAluValid = (cyc < 600) && ($urandom_range(0, 3) != 0);
                bus.iAluRd    = 5'($urandom_range(0, 15));
                bus.iAluData  = $urandom;
            end
            if (lX || !bus.iLdValid) begin
                bus.iLdValid   = (cyc < 600) && ($urandom_range(0, 3) != 0);
                bus.iLdRd      = 5'($urandom_range(16, 31));
                bus.iLdFunct3  = f3tab[$urandom_range(0, 7)];
                bus.iLdByteOff = 2'($urandom_range(0, 3));
                bus.iLdWord    = $urandom;
            end
        end
        idle_inputs();
        chk("alu_q_drained", aluQ.size(), 0);
        chk("ld_q_drained", ldQ.size(), 0);

        // Reset with two entries queued.
        @(posedge clk); #1;
        bus.iAluValid = 1'b1; bus.iAluRd = 5'd10; bus.iAluData = 32'h5555_0000;
        bus.iLdValid = 1'b1; bus.iLdRd = 5'd11; bus.iLdFunct3 = LW;
        bus.iLdByteOff = 2'd0; bus.iLdWord = 32'h6666_0000;
        bus.iIssueValid = 1'b1; bus.iIssueRd = 5'd10;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_we", {31'd0, bus.oRdWe}, 32'd0);
        chk("mrst_busy", bus.oBusy, 32'd0);
        chk("mrst_ready", {30'd0, bus.oAluReady, bus.oLdReady}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mrst_quiet%0d", i), {30'd0, bus.oRdWe, bus.oLdErr}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
